// File: rtl/framer_pkg.sv
// rtl/framer_pkg.sv - shared types and constants for the ciphertext framer
package framer_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    LEN,
    PAYLOAD,
    CHK
  } framer_state_t;

  localparam byte_t DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two FIFO with combinational head read
module byte_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push at full is accepted alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ctxt_framer.sv
// rtl/ctxt_framer.sv - frames cipher bytes as SOF/LEN/payload[/checksum]; FRAMER_CHECKSUM_EN adds checksum
module ctxt_framer
  import framer_pkg::*;
#(
  parameter int    FRAME_LEN  = 16,
  parameter int    FIFO_DEPTH = 32,
  parameter byte_t SOF_BYTE   = DEFAULT_SOF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  byte_t ctxt_char,
  input  logic  din_valid,
  input  logic  flush,
  output byte_t frame_byte,
  output logic  frame_valid,
  input  logic  frame_ready,
  output logic  frame_last,
  output logic  overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  byte_t         fifo_dout;

  framer_state_t state, state_n;
  byte_t         byte_n;
  logic          valid_n;
  logic          last_n;
  byte_t         len_q, len_n, len_sel;
  byte_t         pcnt, pcnt_n;
  logic          can_load;
  logic          start_cond;
  logic          start_taken;
  logic          finish;
  logic          flush_pending;
`ifdef FRAMER_CHECKSUM_EN
  byte_t         chk;
`endif

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (din_valid),
    .din   (ctxt_char),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign can_load   = !frame_valid || frame_ready;
  assign start_cond = (int'(fifo_count) >= FRAME_LEN) || (flush_pending && !fifo_empty);
  assign len_sel    = (int'(fifo_count) >= FRAME_LEN) ? byte_t'(FRAME_LEN) : byte_t'(fifo_count);

  // Next-state and output-register loading; each state names the byte currently held.
  always_comb begin
    state_n     = state;
    byte_n      = frame_byte;
    valid_n     = frame_valid;
    last_n      = frame_last;
    len_n       = len_q;
    pcnt_n      = pcnt;
    fifo_pop    = 1'b0;
    start_taken = 1'b0;
    finish      = 1'b0;

    case (state)
      IDLE: finish = 1'b1;
      SOF: begin
        if (can_load) begin
          byte_n  = len_q;
          valid_n = 1'b1;
          last_n  = 1'b0;
          state_n = LEN;
        end
      end
      LEN, PAYLOAD: begin
        if (pcnt != 8'd0) begin
          if (can_load) begin
            fifo_pop = 1'b1;
            byte_n   = fifo_dout;
            valid_n  = 1'b1;
`ifdef FRAMER_CHECKSUM_EN
            last_n   = 1'b0;
`else
            last_n   = (pcnt == 8'd1);
`endif
            pcnt_n   = pcnt - 8'd1;
            state_n  = PAYLOAD;
          end
        end else begin
`ifdef FRAMER_CHECKSUM_EN
          if (can_load) begin
            byte_n  = chk;
            valid_n = 1'b1;
            last_n  = 1'b1;
            state_n = CHK;
          end
`else
          finish = 1'b1;
`endif
        end
      end
      CHK:     finish = 1'b1;
      default: state_n = IDLE;
    endcase

    // End of frame (or idle): start the next frame straight away when possible.
    if (finish && can_load) begin
      if (start_cond) begin
        byte_n      = SOF_BYTE;
        valid_n     = 1'b1;
        last_n      = 1'b0;
        len_n       = len_sel;
        pcnt_n      = len_sel;
        start_taken = 1'b1;
        state_n     = SOF;
      end else begin
        byte_n  = 8'h00;
        valid_n = 1'b0;
        last_n  = 1'b0;
        state_n = IDLE;
      end
    end
  end

  // FSM state, latched frame length, payload countdown and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= 8'h00;
      pcnt        <= 8'h00;
      frame_byte  <= 8'h00;
      frame_valid <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      state       <= state_n;
      len_q       <= len_n;
      pcnt        <= pcnt_n;
      frame_byte  <= byte_n;
      frame_valid <= valid_n;
      frame_last  <= last_n;
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  // Running XOR of popped payload, restarted as each frame begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk <= 8'h00;
    end else if (start_taken) begin
      chk <= 8'h00;
    end else if (fifo_pop) begin
      chk <= chk ^ fifo_dout;
    end
  end
`endif

  // Pending flush survives until a frame starts or there is nothing left to close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pending <= 1'b0;
    end else begin
      flush_pending <= (flush_pending && !(start_taken || (state == IDLE && fifo_empty))) || flush;
    end
  end

  // Sticky drop indicator: a byte arrived when the FIFO had no room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (din_valid && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctxt_framer.sv
// tb/tb_ctxt_framer.sv - scoreboard bench for ctxt_framer
module tb_ctxt_framer;
  import framer_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  byte_t ctxt_char;
  logic  din_valid;
  logic  flush;
  byte_t frame_byte;
  logic  frame_valid;
  logic  frame_ready;
  logic  frame_last;
  logic  overflow;

  int total = 0;
  int bad   = 0;

  logic [8:0] sb [$];
  byte_t      pl [$];

  ctxt_framer #(
    .FRAME_LEN  (16),
    .FIFO_DEPTH (32),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctxt_char   (ctxt_char),
    .din_valid   (din_valid),
    .flush       (flush),
    .frame_byte  (frame_byte),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_last  (frame_last),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted output byte is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte got=%h last=%b expected=none", frame_byte, frame_last);
      end else begin
        logic [8:0] exp_e;
        exp_e = sb.pop_front();
        if ({frame_last, frame_byte} !== exp_e) begin
          bad++;
          $display("FAIL frame_byte got=%h last=%b expected=%h last=%b",
                   frame_byte, frame_last, exp_e[7:0], exp_e[8]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic fill_pl(input int n, input byte_t base);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(base + byte_t'(i));
  endtask

  function automatic byte_t xor_pl();
    byte_t x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  task automatic expect_frame(input int first, input int n, input byte_t chk);
    sb.push_back({1'b0, 8'hA5});
    sb.push_back({1'b0, byte_t'(n)});
    for (int i = 0; i < n; i++) begin
`ifdef FRAMER_CHECKSUM_EN
      sb.push_back({1'b0, pl[first + i]});
`else
      sb.push_back({(i == n - 1), pl[first + i]});
`endif
    end
`ifdef FRAMER_CHECKSUM_EN
    sb.push_back({1'b1, chk});
`endif
  endtask

  task automatic push_pl();
    foreach (pl[i]) begin
      @(posedge clk); #1;
      ctxt_char = pl[i];
      din_valid = 1'b1;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, sb.size(), 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (frame_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    byte_t hold_b;
    logic  hold_v;
    rst_n       = 1'b0;
    ctxt_char   = 8'h00;
    din_valid   = 1'b0;
    flush       = 1'b0;
    frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte", frame_byte, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_last", frame_last, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // 16-byte burst fills exactly one frame.
    fill_pl(16, 8'h00);
    expect_frame(0, 16, 8'h00);
    push_pl();
    drain("drain_full16");
    check("no_overflow_full16", overflow, 0);

    // Partial frames closed by flush.
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    expect_frame(0, 3, 8'h00);
    push_pl();
    pulse_flush();
    drain("drain_flush_a");
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h44);
    expect_frame(0, 3, 8'h77);
    push_pl();
    pulse_flush();
    drain("drain_flush_b");

    // Flush with nothing buffered produces nothing, then normal operation resumes.
    pulse_flush();
    quiet("flush_empty_quiet", 20);
    fill_pl(16, 8'h20);
    expect_frame(0, 16, xor_pl());
    push_pl();
    drain("drain_after_empty_flush");

    // Backpressure mid-payload holds the output register.
    fill_pl(16, 8'h80);
    expect_frame(0, 16, xor_pl());
    push_pl();
    repeat (4) @(posedge clk);
    #1 frame_ready = 1'b0;
    @(negedge clk);
    hold_b = frame_byte;
    hold_v = frame_valid;
    check("stall_valid", hold_v, 1);
    repeat (4) begin
      @(negedge clk);
      check("stall_byte", frame_byte, hold_b);
      check("stall_valid_hold", frame_valid, hold_v);
    end
    @(posedge clk); #1 frame_ready = 1'b1;
    drain("drain_stall");

    // 33 bytes against a stalled output: the last one is dropped.
    frame_ready = 1'b0;
    fill_pl(33, 8'h40);
    push_pl();
    @(negedge clk);
    check("overflow_set", overflow, 1);
    begin
      byte_t x0 = 8'h00;
      byte_t x1 = 8'h00;
      for (int i = 0; i < 16; i++) begin
        x0 ^= pl[i];
        x1 ^= pl[16 + i];
      end
      expect_frame(0, 16, x0);
      expect_frame(16, 16, x1);
    end
    @(posedge clk); #1 frame_ready = 1'b1;
    drain("drain_overflow");
    check("overflow_sticky", overflow, 1);
    quiet("no_frame_for_dropped", 10);

    // Reset during payload aborts the frame.
    fill_pl(16, 8'hC0);
    expect_frame(0, 16, xor_pl());
    push_pl();
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_valid", frame_valid, 1);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("reset_mid_byte", frame_byte, 0);
    check("reset_mid_valid", frame_valid, 0);
    check("reset_mid_last", frame_last, 0);
    check("reset_mid_overflow", overflow, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    quiet("post_reset_quiet", 20);
    fill_pl(16, 8'hD0);
    expect_frame(0, 16, xor_pl());
    pl.pop_back();
    push_pl();
    quiet("fifteen_bytes_quiet", 10);
    pl.delete(); pl.push_back(8'hDF);
    push_pl();
    drain("drain_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
